// File: rtl/quicksort_seq.sv
// Frame sequencer for the toggle-commanded quicksort core: loads a frame,
// sorts it in the core and drains the sorted words onto a valid/ready stream.
module quicksort_seq #(
    parameter int A_D_MSB = 7,
    parameter int A_P_MSB = 3,
    parameter int CMD_GAP = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               enable,
    input  logic [A_D_MSB:0]   in_data,
    input  logic               in_valid,
    input  logic               in_last,
    output logic               in_ready,
    output logic [A_D_MSB:0]   out_data,
    output logic               out_valid,
    output logic               out_last,
    input  logic               out_ready,
    output logic [A_D_MSB:0]   qs_rx_data,
    output logic               qs_push,
    output logic               qs_pop,
    output logic               qs_clear,
    output logic               qs_sort,
    input  logic [A_D_MSB:0]   qs_tx_data,
    input  logic               qs_full,
    input  logic               qs_empty,
    input  logic               qs_idle,
    output logic               busy,
    output logic               ovf,
    output logic [A_P_MSB+1:0] count
);

    localparam int CW = A_P_MSB + 2;
    localparam int GW = $clog2(CMD_GAP + 1);
    localparam logic [GW-1:0] GAP_END = GW'(CMD_GAP);
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FILL,
        S_SORT,
        S_LOAD,
        S_DRAIN,
        S_WAIT
    } state_t;

    state_t            r_state, w_state_nxt;
    state_t            r_ret, w_ret_nxt;
    logic [GW-1:0]     r_gap, w_gap_nxt;
    logic [CW-1:0]     r_count, w_count_nxt;
    logic              r_ovf, w_ovf_nxt;
    logic [A_D_MSB:0]  r_rx_data, w_rx_data_nxt;
    logic              r_push, w_push_nxt;
    logic              r_pop, w_pop_nxt;
    logic              r_clear, w_clear_nxt;
    logic              r_sort, w_sort_nxt;
    logic [A_D_MSB:0]  r_out_data, w_out_data_nxt;
    logic              r_out_last, w_out_last_nxt;
    logic              w_in_ready;
    logic              w_out_valid;

    // Handshake qualifiers are gated by enable so an abort takes effect at once.
    assign w_in_ready  = enable && (r_state == S_FILL);
    assign w_out_valid = enable && (r_state == S_DRAIN);

    // NOTE: every w_*_nxt gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        w_state_nxt    = r_state;
        w_ret_nxt      = r_ret;
        w_gap_nxt      = r_gap;
        w_count_nxt    = r_count;
        w_ovf_nxt      = r_ovf;
        w_rx_data_nxt  = r_rx_data;
        w_push_nxt     = r_push;
        w_pop_nxt      = r_pop;
        w_clear_nxt    = r_clear;
        w_sort_nxt     = r_sort;
        w_out_data_nxt = r_out_data;
        w_out_last_nxt = r_out_last;

        if (!enable) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_CLEAR;
                    w_count_nxt = '0;
                end
                S_CLEAR: begin
                    w_clear_nxt = ~r_clear;
                    w_ret_nxt   = S_FILL;
                    w_gap_nxt   = '0;
                    w_state_nxt = S_WAIT;
                end
                S_FILL: begin
                    if (in_valid) begin
                        if (!qs_full) begin
                            w_rx_data_nxt = in_data;
                            w_push_nxt    = ~r_push;
                            if (r_count != CNT_MAX) begin
                                w_count_nxt = r_count + CNT_ONE;
                            end
                            w_ret_nxt   = in_last ? S_SORT : S_FILL;
                            w_gap_nxt   = '0;
                            w_state_nxt = S_WAIT;
                        end else begin
                            // Core is full: the word is consumed but lost.
                            w_ovf_nxt = 1'b1;
                            if (in_last) begin
                                w_state_nxt = S_SORT;
                            end
                        end
                    end
                end
                S_SORT: begin
                    if (r_count == '0) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_sort_nxt  = ~r_sort;
                        w_ret_nxt   = S_LOAD;
                        w_gap_nxt   = '0;
                        w_state_nxt = S_WAIT;
                    end
                end
                S_LOAD: begin
                    if (qs_empty && (r_count != '0)) begin
                        w_ovf_nxt   = 1'b1;
                        w_count_nxt = '0;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_out_data_nxt = qs_tx_data;
                        w_out_last_nxt = (r_count == CNT_ONE);
                        w_state_nxt    = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        w_pop_nxt = ~r_pop;
                        if (r_count != '0) begin
                            w_count_nxt = r_count - CNT_ONE;
                        end
                        w_ret_nxt   = (r_count == CNT_ONE) ? S_IDLE : S_LOAD;
                        w_gap_nxt   = '0;
                        w_state_nxt = S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Fixed settle time first, then hold until the core reports idle.
                    if (r_gap != GAP_END) begin
                        w_gap_nxt = r_gap + GW'(1);
                    end else if (qs_idle) begin
                        w_state_nxt = r_ret;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_ret      <= S_IDLE;
            r_gap      <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
            r_rx_data  <= '0;
            r_push     <= 1'b0;
            r_pop      <= 1'b0;
            r_clear    <= 1'b0;
            r_sort     <= 1'b0;
            r_out_data <= '0;
            r_out_last <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ret      <= w_ret_nxt;
            r_gap      <= w_gap_nxt;
            r_count    <= w_count_nxt;
            r_ovf      <= w_ovf_nxt;
            r_rx_data  <= w_rx_data_nxt;
            r_push     <= w_push_nxt;
            r_pop      <= w_pop_nxt;
            r_clear    <= w_clear_nxt;
            r_sort     <= w_sort_nxt;
            r_out_data <= w_out_data_nxt;
            r_out_last <= w_out_last_nxt;
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = w_out_valid;
    assign out_data   = r_out_data;
    assign out_last   = r_out_last;
    assign qs_rx_data = r_rx_data;
    assign qs_push    = r_push;
    assign qs_pop     = r_pop;
    assign qs_clear   = r_clear;
    assign qs_sort    = r_sort;
    assign busy       = (r_state != S_IDLE);
    assign ovf        = r_ovf;
    assign count      = r_count;

endmodule
